// File: rtl/inst_loader_pkg.sv
// Shared widths, loader state encoding and helpers for the instruction loader.
package inst_loader_pkg;

    localparam int unsigned BYTE_LEN       = 8;
    localparam int unsigned ADDR_LEN       = 32;
    localparam int unsigned INSTR_LEN      = 32;
    localparam int unsigned BYTES_PER_WORD = INSTR_LEN / BYTE_LEN;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_RECV  = 2'd1,
        LD_WRITE = 2'd2,
        LD_DONE  = 2'd3
    } ld_state_e;

    // A load request is legal when it asks for at least one word and no
    // more words than the target memory holds.
    function automatic logic count_legal(input int unsigned cnt,
                                         input int unsigned depth);
        return (cnt != 0) && (cnt <= depth);
    endfunction

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Big-endian byte packer: shifts incoming bytes into a 32-bit word and flags
// the handshake that completes the word.
module byte_packer
    import inst_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 accept_i,
    input  logic [BYTE_LEN-1:0]  byte_i,
    output logic [INSTR_LEN-1:0] word_o,
    output logic                 word_full_o
);

    logic [INSTR_LEN-1:0] shift_q, shift_d;
    logic [1:0]           cnt_q, cnt_d;

    // Word as it will look once the byte currently offered is shifted in;
    // lets the parent capture the finished word on the completing handshake.
    assign word_o      = {shift_q[INSTR_LEN-BYTE_LEN-1:0], byte_i};
    assign word_full_o = accept_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

    // Next shift register / byte index: clear on a new session, shift on accept.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (accept_i) begin
            shift_d = word_o;
            cnt_d   = cnt_q + 2'd1;
        end
    end

    // Shift register and byte counter; reset discards any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: receives a byte stream, packs 4 bytes per instruction
// and writes them to consecutive word addresses while holding the CPU.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned CNT_W = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     word_count,
    input  logic                 byte_valid,
    input  logic [BYTE_LEN-1:0]  byte_data,
    output logic                 byte_ready,
    output logic                 mem_we,
    output logic [ADDR_LEN-1:0]  mem_addr,
    output logic [INSTR_LEN-1:0] mem_wdata,
    output logic                 busy,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 error
);

    ld_state_e            state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [CNT_W-1:0]     word_idx_q, word_idx_d;
    logic                 error_q, error_d;
    logic [ADDR_LEN-1:0]  addr_q, addr_d;
    logic [INSTR_LEN-1:0] wdata_q, wdata_d;

    logic                 legal;
    logic                 accept;
    logic                 packer_clear;
    logic [INSTR_LEN-1:0] packed_word;
    logic                 word_full;

    assign legal        = count_legal(32'(word_count), DEPTH);
    assign accept       = byte_valid && byte_ready;
    assign packer_clear = (state_q == LD_IDLE) && start && legal;

    byte_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (packer_clear),
        .accept_i    (accept),
        .byte_i      (byte_data),
        .word_o      (packed_word),
        .word_full_o (word_full)
    );

    // All outputs decode from registered state / datapath registers.
    assign byte_ready = (state_q == LD_RECV);
    assign mem_we     = (state_q == LD_WRITE);
    assign busy       = (state_q == LD_RECV) || (state_q == LD_WRITE);
    assign cpu_hold   = busy;
    assign done       = (state_q == LD_DONE);
    assign error      = error_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

    // Next-state and datapath updates. The memory-port registers are loaded on
    // the handshake completing a word, so they are valid throughout WRITE and
    // hold their values afterwards.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        error_d    = error_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            LD_IDLE: begin
                if (start) begin
                    if (!legal) begin
                        error_d = 1'b1;
                    end else begin
                        count_d    = word_count;
                        error_d    = 1'b0;
                        word_idx_d = '0;
                        state_d    = LD_RECV;
                    end
                end
            end
            LD_RECV: begin
                if (word_full) begin
                    addr_d  = ADDR_LEN'({word_idx_q, 2'b00});
                    wdata_d = packed_word;
                    state_d = LD_WRITE;
                end
            end
            LD_WRITE: begin
                if (word_idx_q == count_q - CNT_W'(1)) begin
                    state_d = LD_DONE;
                end else begin
                    word_idx_d = word_idx_q + CNT_W'(1);
                    state_d    = LD_RECV;
                end
            end
            LD_DONE: begin
                state_d = LD_IDLE;
            end
            default: begin
                state_d = LD_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Word counter, error flag and memory-port registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            word_idx_q <= '0;
            error_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            error_q    <= error_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed sessions plus random loads,
// compared against a byte-list reference model.
module tb_inst_loader;
    import inst_loader_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned CNT_W = 9;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [CNT_W-1:0]     word_count;
    logic                 byte_valid;
    logic [7:0]           byte_data;
    logic                 byte_ready;
    logic                 mem_we;
    logic [ADDR_LEN-1:0]  mem_addr;
    logic [INSTR_LEN-1:0] mem_wdata;
    logic                 busy;
    logic                 cpu_hold;
    logic                 done;
    logic                 error;

    always #5 clk = ~clk;

    inst_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    wr_t        wr_q[$];
    int         hs_q[$];
    int         done_q[$];
    logic [7:0] tx[$];

    // Observation: record writes, byte handshakes and done pulses per cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mem_we === 1'b1) wr_q.push_back('{addr: mem_addr, data: mem_wdata, cyc: cyc});
        if (byte_valid === 1'b1 && byte_ready === 1'b1) hs_q.push_back(cyc);
        if (done === 1'b1) done_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: word i is bytes 4i..4i+3 of the stream, first byte in the MSBs.
    function automatic logic [31:0] model_word(input int i);
        return (32'(tx[4*i]) << 24) | (32'(tx[4*i+1]) << 16) |
               (32'(tx[4*i+2]) << 8) | 32'(tx[4*i+3]);
    endfunction

    function automatic void fill_random(input int nbytes);
        tx.delete();
        for (int i = 0; i < nbytes; i++) tx.push_back(8'($urandom_range(0, 255)));
    endfunction

    // Called at posedge+1; returns at posedge+1.
    task automatic pulse_start(input int wc);
        start      = 1'b1;
        word_count = CNT_W'(wc);
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    // Offers every byte of tx, waiting for byte_ready, with gap idle cycles
    // between bytes. inject raises a stray start alongside the second byte.
    task automatic send_bytes(input int gap, input bit inject);
        bit got;
        for (int i = 0; i < tx.size(); i++) begin
            byte_valid = 1'b1;
            byte_data  = tx[i];
            if (inject && i == 1) begin
                start      = 1'b1;
                word_count = CNT_W'(5);
            end
            got = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge clk);
                if (byte_ready === 1'b1) got = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            if (!got) begin
                check("byte_accept_timeout", 32'(got), 32'd1);
                break;
            end
            byte_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        byte_valid = 1'b0;
    endtask

    task automatic run_session(input int wc, input int gap, input bit inject, input string tag);
        bit got;
        int exp_cyc;
        wr_q.delete(); hs_q.delete(); done_q.delete();
        pulse_start(wc);
        send_bytes(gap, inject);
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk); #1;
            if (done_q.size() != 0) got = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        repeat (3) begin @(posedge clk); #1; end
        check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(wc));
        for (int i = 0; i < wr_q.size() && i < wc; i++) begin
            check({tag, "_addr"}, wr_q[i].addr, 32'(4 * i));
            check({tag, "_data"}, wr_q[i].data, model_word(i));
            exp_cyc = (hs_q.size() > 4 * i + 3) ? hs_q[4 * i + 3] + 1 : -1;
            check({tag, "_wr_cycle"}, 32'(wr_q[i].cyc), 32'(exp_cyc));
        end
        check({tag, "_ndone"}, 32'(done_q.size()), 32'd1);
        if (wr_q.size() != 0 && done_q.size() != 0)
            check({tag, "_done_cycle"}, 32'(done_q[0]), 32'(wr_q[wr_q.size()-1].cyc + 1));
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_hold_after"}, 32'(cpu_hold), 32'd0);
        check({tag, "_ready_after"}, 32'(byte_ready), 32'd0);
        check({tag, "_error_after"}, 32'(error), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        word_count = '0;
        byte_valid = 1'b0;
        byte_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Normal load, back-to-back bytes.
        tx = '{8'h34, 8'h00, 8'h00, 8'h00, 8'h20, 8'h01, 8'h00, 8'h01};
        run_session(2, 0, 1'b0, "normal");
        if (wr_q.size() == 2) begin
            check("normal_w0", wr_q[0].data, 32'h3400_0000);
            check("normal_w1", wr_q[1].data, 32'h2001_0001);
        end

        // Stalled stream, 3 idle cycles between bytes.
        run_session(2, 3, 1'b0, "stalled");

        // Illegal counts.
        wr_q.delete(); hs_q.delete();
        pulse_start(0);
        @(negedge clk);
        check("ill0_error", 32'(error), 32'd1);
        check("ill0_ready", 32'(byte_ready), 32'd0);
        @(posedge clk); #1;
        pulse_start(257);
        byte_valid = 1'b1;
        byte_data  = 8'hA5;
        repeat (5) begin @(posedge clk); #1; end
        byte_valid = 1'b0;
        check("ill257_error", 32'(error), 32'd1);
        check("ill257_busy", 32'(busy), 32'd0);
        check("ill_no_handshake", 32'(hs_q.size()), 32'd0);
        check("ill_no_write", 32'(wr_q.size()), 32'd0);
        fill_random(4);
        run_session(1, 0, 1'b0, "after_err");

        // Full depth: byte k of word i is i*4+k.
        tx.delete();
        for (int i = 0; i < 256; i++)
            for (int k = 0; k < 4; k++) tx.push_back(8'(i * 4 + k));
        run_session(256, 0, 1'b0, "full");
        if (wr_q.size() != 0) check("full_last_addr", wr_q[wr_q.size()-1].addr, 32'h0000_03FC);

        // Reset in the middle of word 0.
        wr_q.delete();
        pulse_start(1);
        fill_random(2);
        send_bytes(0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hold", 32'(cpu_hold), 32'd0);
        check("midrst_ready", 32'(byte_ready), 32'd0);
        check("midrst_we", 32'(mem_we), 32'd0);
        check("midrst_addr", mem_addr, 32'd0);
        check("midrst_wdata", mem_wdata, 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        check("midrst_no_write", 32'(wr_q.size()), 32'd0);
        @(posedge clk); #1;
        fill_random(4);
        run_session(1, 0, 1'b0, "post_rst");

        // Stray start during RECV must not change the word count.
        fill_random(8);
        run_session(2, 0, 1'b1, "busy_start");
        repeat (10) begin @(posedge clk); #1; end
        check("busy_start_total_writes", 32'(wr_q.size()), 32'd2);

        // Random sessions.
        for (int r = 0; r < 6; r++) begin
            int wc;
            int gap;
            wc  = $urandom_range(1, 6);
            gap = $urandom_range(0, 2);
            fill_random(4 * wc);
            run_session(wc, gap, 1'b0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Write-side counterpart of the instruction memory; the fetch path remains the reader.
- Receives a byte stream, for example from a UART receiver or the testbench, and packs each group of 4 bytes big-endian into a 32-bit instruction.
- Writes each instruction into a writable instruction-memory port at consecutive word-aligned byte addresses starting at 0.
- Holds the CPU (cpu_hold) while a load is in progress, so a new program can replace the initial contents without resynthesis.

Parameters:
- DEPTH, 256, number of instruction words in the target memory; the largest legal word_count.
- CNT_W, 9, width of word_count; must be able to hold DEPTH.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a load session; sampled in IDLE only.
- word_count  in  CNT_W  number of words to load; sampled when start is accepted.
- byte_valid  in  1  byte_data holds a valid byte.
- byte_data  in  8  incoming byte; the first byte of a word goes to bits 31:24.
- byte_ready  out  1  loader can accept a byte.
- mem_we  out  1  instruction-memory write enable, one cycle per word.
- mem_addr  out  `ADDR_LEN  byte address, word-aligned; bits 1:0 are always 0.
- mem_wdata  out  `INSTR_LEN  assembled instruction.
- busy  out  1  a session is active (RECV or WRITE).
- cpu_hold  out  1  CPU must not fetch; equal to busy.
- done  out  1  one-cycle pulse after the last word has been written.
- error  out  1  sticky flag: the last start had an illegal word_count.

Behaviour:
- Reset:
  - State goes to IDLE.
  - byte_ready, mem_we, busy, cpu_hold, done and error are 0.
  - mem_addr and mem_wdata are 0.
  - Word index and byte index are 0; any partial word is discarded.
  - The asynchronous reset has the same effect mid-session; no write is issued for a word in progress.
- State machine states: IDLE, RECV, WRITE, DONE. All outputs are decoded from registered state and datapath registers.
- IDLE:
  - byte_ready is 0.
  - start with word_count==0 or word_count>DEPTH: set error to 1 and stay in IDLE.
  - Otherwise on start: latch word_count, clear error, clear the word and byte indices, go to RECV.
- RECV:
  - byte_ready is 1.
  - On each byte_valid&&byte_ready: shift_reg = {shift_reg[23:0], byte_data}, then byte_idx+1.
  - The handshake that completes the 4th byte moves to WRITE in the next cycle.
  - byte_valid gaps of any length are allowed and lose no data.
- WRITE:
  - byte_ready is 0; mem_we is 1 for exactly this one cycle.
  - mem_addr = {word_idx, 2'b00} zero-extended; mem_wdata = shift_reg.
  - Next state: DONE if word_idx == count-1; otherwise word_idx+1 and back to RECV.
- DONE:
  - done is 1 for one cycle, then IDLE.
  - busy and cpu_hold are already 0 in DONE.
- start outside IDLE is ignored; it is not queued.
- Throughput: at best 5 cycles per word (4 byte handshakes plus 1 write cycle).
- Latency: done appears 1 cycle after the final write.
- mem_addr and mem_wdata hold their last values outside WRITE.
- Maximum load (word_count=DEPTH=256): the final address is 0x3FC; word_idx never wraps.

Decomposition:
- defines.v gets:
  - `BYTE_LEN 8
  - the loader state encoding (`LD_IDLE, `LD_RECV, `LD_WRITE, `LD_DONE, 2 bits)
- The existing `ADDR_LEN and `INSTR_LEN are reused.
- One natural sub-module, byte_packer: the shift register plus a 2-bit byte counter, with a word_full output.
- inst_loader keeps the state machine, the word counter and the memory-port registers.

Test Plan:
- Normal load: start with word_count=2, then bytes 34 00 00 00 20 01 00 01 sent back-to-back -> writes (addr 0x0, data 0x34000000) and then (addr 0x4, data 0x20010001); exactly 2 mem_we pulses; done pulses once, 1 cycle after the second write; busy is 0 afterwards.
- Stalled stream: same data with byte_valid low for 3 cycles between every byte -> identical writes and data; mem_we is never asserted early.
- Illegal count: start with word_count=0, then word_count=257 -> error=1, no mem_we, byte_ready stays 0. A following start with word_count=1 clears error and loads normally.
- Full depth: word_count=256 with bytes generated as (i*4+k) -> last write at addr 0x3FC; 256 writes total, each with the expected data; done pulses once.
- Reset mid-word: rst asserted after 2 bytes of word 0 -> all outputs 0 immediately, no write. A fresh load after release writes correct data at addr 0.
- start while busy: a second start pulse during RECV with word_count=5 -> ignored; the session completes with the original count of 2.
